// File: rtl/ysyx_22041752_axi_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041752_axi_rr_arbiter_pkg
// Description : Shared types and AXI constants for the N-port AXI arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22041752_axi_rr_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4
    } arb_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AXI size field for a full-width beat of the given byte count
    function automatic logic [2:0] axi_size(input int unsigned bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22041752_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041752_rr_picker
// Description : Combinational rotating-priority picker; the pointer index has
//               highest priority, search wraps modulo NUM_PORTS.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041752_rr_picker
    import ysyx_22041752_axi_rr_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_WD    = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_WD-1:0]    ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_WD-1:0]    gnt_idx,
    output logic                 gnt_vld
);

    localparam int SUM_WD = IDX_WD + 1;
    localparam logic [NUM_PORTS-1:0] PORT_ONE = NUM_PORTS'(1);

    logic [IDX_WD-1:0] w_cand [NUM_PORTS];

    // w_cand[i] is the port examined i-th: (ptr + i) mod NUM_PORTS
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cand
        logic [SUM_WD-1:0] w_sum;
        assign w_sum     = {1'b0, ptr} + SUM_WD'(i);
        assign w_cand[i] = (w_sum >= SUM_WD'(NUM_PORTS)) ?
                           IDX_WD'(w_sum - SUM_WD'(NUM_PORTS)) : w_sum[IDX_WD-1:0];
    end

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!gnt_vld && req[w_cand[i]]) begin
                gnt_vld = 1'b1;
                gnt_idx = w_cand[i];
            end
        end
    end

    assign gnt = gnt_vld ? (PORT_ONE << gnt_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/ysyx_22041752_axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041752_axi_rr_arbiter
// Description : Merges NUM_PORTS SRAM-style requesters onto one AXI4 master,
//               single-beat, one outstanding transaction. Round-robin by
//               default; define YSYX_22041752_ARB_FIXED_PRIO_EN for fixed
//               lowest-index-wins priority.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041752_axi_rr_arbiter
    import ysyx_22041752_axi_rr_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_WD   = 32,
    parameter int DATA_WD   = 64,
    parameter int ID_WD     = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           port_en,
    output logic [NUM_PORTS-1:0]           port_ready,
    input  logic [NUM_PORTS*DATA_WD/8-1:0] port_wen,
    input  logic [NUM_PORTS*ADDR_WD-1:0]   port_addr,
    input  logic [NUM_PORTS*DATA_WD-1:0]   port_wdata,
    output logic [DATA_WD-1:0]             port_rdata,
    output logic [NUM_PORTS-1:0]           port_valid,
    output logic                           arvalid,
    input  logic                           arready,
    output logic [ID_WD-1:0]               arid,
    output logic [ADDR_WD-1:0]             araddr,
    output logic [7:0]                     arlen,
    output logic [2:0]                     arsize,
    output logic [1:0]                     arburst,
    input  logic                           rvalid,
    output logic                           rready,
    input  logic [ID_WD-1:0]               rid,
    input  logic [DATA_WD-1:0]             rdata,
    input  logic [1:0]                     rresp,
    input  logic                           rlast,
    output logic                           awvalid,
    input  logic                           awready,
    output logic [ID_WD-1:0]               awid,
    output logic [ADDR_WD-1:0]             awaddr,
    output logic [7:0]                     awlen,
    output logic [2:0]                     awsize,
    output logic [1:0]                     awburst,
    output logic                           wvalid,
    input  logic                           wready,
    output logic [DATA_WD-1:0]             wdata,
    output logic [DATA_WD/8-1:0]           wstrb,
    output logic                           wlast,
    input  logic                           bvalid,
    output logic                           bready,
    input  logic [ID_WD-1:0]               bid,
    input  logic [1:0]                     bresp
);

    localparam int STRB_WD = DATA_WD / 8;
    localparam int IDX_WD  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [2:0] AXI_SIZE = axi_size(STRB_WD);
    localparam logic [NUM_PORTS-1:0] PORT_ONE = NUM_PORTS'(1);

    arb_state_e             r_state;
    logic [IDX_WD-1:0]      r_idx;
    logic [ID_WD-1:0]       r_id;
    logic [ADDR_WD-1:0]     r_addr;
    logic [STRB_WD-1:0]     r_wen;
    logic [DATA_WD-1:0]     r_wdata;
    logic [DATA_WD-1:0]     r_rdata;
    logic [NUM_PORTS-1:0]   r_port_valid;
    logic                   r_arvalid;
    logic                   r_rready;
    logic                   r_awvalid;
    logic                   r_wvalid;
    logic                   r_bready;
    logic                   r_aw_done;
    logic                   r_w_done;

    logic [IDX_WD-1:0]      w_ptr;
    logic [NUM_PORTS-1:0]   w_gnt;
    logic [IDX_WD-1:0]      w_gnt_idx;
    logic                   w_gnt_vld;
    logic                   w_grant;
    logic [STRB_WD-1:0]     w_sel_wen;
    logic [ADDR_WD-1:0]     w_sel_addr;
    logic [DATA_WD-1:0]     w_sel_wdata;
    logic                   w_aw_done_nxt;
    logic                   w_w_done_nxt;
    logic                   w_unused;

    ysyx_22041752_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_WD    (IDX_WD)
    ) u_picker (
        .req     (port_en),
        .ptr     (w_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .gnt_vld (w_gnt_vld)
    );

    // Grants are held off in the completion cycle so a finished port can drop port_en
    assign w_grant     = (r_state == ST_IDLE) && (r_port_valid == '0) && w_gnt_vld && !reset;
    assign port_ready  = w_grant ? w_gnt : '0;
    assign w_sel_wen   = port_wen[w_gnt_idx*STRB_WD +: STRB_WD];
    assign w_sel_addr  = port_addr[w_gnt_idx*ADDR_WD +: ADDR_WD];
    assign w_sel_wdata = port_wdata[w_gnt_idx*DATA_WD +: DATA_WD];

`ifdef YSYX_22041752_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [IDX_WD-1:0] r_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_gnt_idx == IDX_WD'(NUM_PORTS - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`endif

    assign w_aw_done_nxt = r_aw_done || (r_awvalid && awready);
    assign w_w_done_nxt  = r_w_done  || (r_wvalid  && wready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_id         <= '0;
            r_addr       <= '0;
            r_wen        <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_port_valid <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
        end else begin
            r_port_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_idx   <= w_gnt_idx;
                        r_id    <= ID_WD'(w_gnt_idx);
                        r_addr  <= w_sel_addr;
                        r_wen   <= w_sel_wen;
                        r_wdata <= w_sel_wdata;
                        if (w_sel_wen == '0) begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_AR;
                        end else begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= ST_AW_W;
                        end
                    end
                end
                ST_AR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (rvalid) begin
                        r_rready     <= 1'b0;
                        r_rdata      <= rdata;
                        r_port_valid <= PORT_ONE << r_idx;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_AW_W: begin
                    // AW and W complete independently, in either order
                    if (r_awvalid && awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && wready) begin
                        r_wvalid <= 1'b0;
                    end
                    r_aw_done <= w_aw_done_nxt;
                    r_w_done  <= w_w_done_nxt;
                    if (w_aw_done_nxt && w_w_done_nxt) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_B;
                    end
                end
                ST_B: begin
                    if (bvalid) begin
                        r_bready     <= 1'b0;
                        r_port_valid <= PORT_ONE << r_idx;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign port_rdata = r_rdata;
    assign port_valid = r_port_valid;

    assign arvalid = r_arvalid;
    assign arid    = r_id;
    assign araddr  = r_addr;
    assign arlen   = 8'd0;
    assign arsize  = AXI_SIZE;
    assign arburst = AXI_BURST_INCR;
    assign rready  = r_rready;

    assign awvalid = r_awvalid;
    assign awid    = r_id;
    assign awaddr  = r_addr;
    assign awlen   = 8'd0;
    assign awsize  = AXI_SIZE;
    assign awburst = AXI_BURST_INCR;
    assign wvalid  = r_wvalid;
    assign wdata   = r_wdata;
    assign wstrb   = r_wen;
    assign wlast   = 1'b1;
    assign bready  = r_bready;

    // Response codes and IDs are not checked with a single outstanding transaction
    assign w_unused = ^{rid, rresp, rlast, bid, bresp};

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041752_axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22041752_axi_rr_arbiter
// Description : Directed self-checking bench for the 3-port AXI arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041752_axi_rr_arbiter;

    localparam int NP = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   port_en = '0;
    logic [2:0]   port_ready;
    logic [23:0]  port_wen = '0;
    logic [95:0]  port_addr = '0;
    logic [191:0] port_wdata = '0;
    logic [63:0]  port_rdata;
    logic [2:0]   port_valid;
    logic         arvalid, arready = 1'b0;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         rvalid = 1'b0, rready;
    logic [63:0]  rdata = '0;
    logic         awvalid, awready = 1'b0;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         wvalid, wready = 1'b0;
    logic [63:0]  wdata;
    logic [7:0]   wstrb;
    logic         wlast;
    logic         bvalid = 1'b0, bready;

    int n_checks = 0;
    int n_pass   = 0;

    ysyx_22041752_axi_rr_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_WD   (32),
        .DATA_WD   (64),
        .ID_WD     (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .port_en    (port_en),
        .port_ready (port_ready),
        .port_wen   (port_wen),
        .port_addr  (port_addr),
        .port_wdata (port_wdata),
        .port_rdata (port_rdata),
        .port_valid (port_valid),
        .arvalid    (arvalid),
        .arready    (arready),
        .arid       (arid),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .rvalid     (rvalid),
        .rready     (rready),
        .rid        (4'd0),
        .rdata      (rdata),
        .rresp      (2'b00),
        .rlast      (1'b1),
        .awvalid    (awvalid),
        .awready    (awready),
        .awid       (awid),
        .awaddr     (awaddr),
        .awlen      (awlen),
        .awsize     (awsize),
        .awburst    (awburst),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wlast      (wlast),
        .bvalid     (bvalid),
        .bready     (bready),
        .bid        (4'd0),
        .bresp      (2'b00)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        port_en = 3'b111;
        tick;
        @(negedge clk);
        n_checks++; if (port_ready !== 3'b000) $display("FAIL reset_port_ready: got %b expected 000", port_ready); else n_pass++;
        n_checks++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) $display("FAIL reset_valids: got %b expected 00000", {arvalid, awvalid, wvalid, rready, bready}); else n_pass++;
        n_checks++; if (port_valid !== 3'b000) $display("FAIL reset_port_valid: got %b expected 000", port_valid); else n_pass++;
        n_checks++; if ({araddr, arid, port_rdata} !== '0) $display("FAIL reset_regs: araddr %h arid %h rdata %h expected all 0", araddr, arid, port_rdata); else n_pass++;
        port_en = 3'b000;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_single_read;
        tick;
        port_en = 3'b010;
        port_addr[63:32] = 32'h8000_0010;
        port_wen[15:8] = 8'h00;
        @(negedge clk);
        n_checks++; if (port_ready !== 3'b010) $display("FAIL rd_port_ready: got %b expected 010", port_ready); else n_pass++;
        tick;
        port_en = 3'b000;
        arready = 1'b1;
        @(negedge clk);
        n_checks++; if (arvalid !== 1'b1) $display("FAIL rd_arvalid: got %b expected 1", arvalid); else n_pass++;
        n_checks++; if (arid !== 4'd1) $display("FAIL rd_arid: got %h expected 1", arid); else n_pass++;
        n_checks++; if (araddr !== 32'h8000_0010) $display("FAIL rd_araddr: got %h expected 80000010", araddr); else n_pass++;
        n_checks++; if ({arlen, arsize, arburst} !== {8'd0, 3'd3, 2'b01}) $display("FAIL rd_fixed_fields: got len %h size %h burst %b", arlen, arsize, arburst); else n_pass++;
        tick;
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        n_checks++; if ({rready, arvalid} !== 2'b10) $display("FAIL rd_rready: got rready %b arvalid %b expected 1 0", rready, arvalid); else n_pass++;
        tick;
        rvalid = 1'b0;
        rdata = '0;
        @(negedge clk);
        n_checks++; if (port_valid !== 3'b010) $display("FAIL rd_port_valid: got %b expected 010", port_valid); else n_pass++;
        n_checks++; if (port_rdata !== 64'hDEAD_BEEF_0000_0001) $display("FAIL rd_port_rdata: got %h expected deadbeef00000001", port_rdata); else n_pass++;
        tick;
        @(negedge clk);
        n_checks++; if (port_valid !== 3'b000) $display("FAIL rd_valid_single_pulse: got %b expected 000", port_valid); else n_pass++;
    endtask

    // Pointer is 2 here; port 0 alone must win and the pointer moves to 1
    task automatic test_write_split;
        tick;
        port_en = 3'b001;
        port_wen[7:0] = 8'h0F;
        port_addr[31:0] = 32'h8000_0100;
        port_wdata[63:0] = 64'h1122_3344_5566_7788;
        @(negedge clk);
        n_checks++; if (port_ready !== 3'b001) $display("FAIL wr_port_ready: got %b expected 001", port_ready); else n_pass++;
        tick;
        port_en = 3'b000;
        awready = 1'b1;
        @(negedge clk);
        n_checks++; if ({awvalid, wvalid} !== 2'b11) $display("FAIL wr_aw_w_valid: got %b expected 11", {awvalid, wvalid}); else n_pass++;
        n_checks++; if ({wstrb, wdata, wlast} !== {8'h0F, 64'h1122_3344_5566_7788, 1'b1}) $display("FAIL wr_wchan: strb %h data %h last %b", wstrb, wdata, wlast); else n_pass++;
        n_checks++; if ({awid, awaddr, awlen, awsize, awburst} !== {4'd0, 32'h8000_0100, 8'd0, 3'd3, 2'b01}) $display("FAIL wr_awchan: id %h addr %h len %h size %h burst %b", awid, awaddr, awlen, awsize, awburst); else n_pass++;
        tick;
        awready = 1'b0;
        @(negedge clk);
        n_checks++; if ({awvalid, wvalid} !== 2'b01) $display("FAIL wr_aw_dropped: got %b expected 01", {awvalid, wvalid}); else n_pass++;
        tick;
        wready = 1'b1;
        @(negedge clk);
        n_checks++; if ({wvalid, bready} !== 2'b10) $display("FAIL wr_w_held: got wvalid %b bready %b expected 1 0", wvalid, bready); else n_pass++;
        tick;
        wready = 1'b0;
        @(negedge clk);
        n_checks++; if ({wvalid, bready} !== 2'b01) $display("FAIL wr_bready: got wvalid %b bready %b expected 0 1", wvalid, bready); else n_pass++;
        tick;
        bvalid = 1'b1;
        @(negedge clk);
        n_checks++; if (port_valid !== 3'b000) $display("FAIL wr_early_valid: got %b expected 000", port_valid); else n_pass++;
        tick;
        bvalid = 1'b0;
        @(negedge clk);
        n_checks++; if (port_valid !== 3'b001) $display("FAIL wr_port_valid: got %b expected 001", port_valid); else n_pass++;
        n_checks++; if (port_rdata !== 64'hDEAD_BEEF_0000_0001) $display("FAIL wr_rdata_kept: got %h expected deadbeef00000001", port_rdata); else n_pass++;
        port_wen[7:0] = 8'h00;
    endtask

    // Ports 0 and 1 both request with the pointer at 1
    task automatic test_wrap_ptr;
        logic [2:0] first_oh;
        logic [2:0] second_oh;
`ifdef YSYX_22041752_ARB_FIXED_PRIO_EN
        first_oh  = 3'b001;
        second_oh = 3'b010;
`else
        first_oh  = 3'b010;
        second_oh = 3'b001;
`endif
        tick;
        port_en = 3'b011;
        port_addr[31:0] = 32'h8000_0200;
        port_addr[63:32] = 32'h8000_0210;
        @(negedge clk);
        n_checks++; if (port_ready !== first_oh) $display("FAIL wrap_first_grant: got %b expected %b", port_ready, first_oh); else n_pass++;
        tick;
        port_en = second_oh;
        arready = 1'b1;
        tick;
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = 64'h0000_0000_0000_00A5;
        tick;
        rvalid = 1'b0;
        @(negedge clk);
        n_checks++; if ({port_valid, port_ready} !== {first_oh, 3'b000}) $display("FAIL wrap_no_grant_on_valid: valid %b ready %b expected %b 000", port_valid, port_ready, first_oh); else n_pass++;
        tick;
        @(negedge clk);
        n_checks++; if (port_ready !== second_oh) $display("FAIL wrap_second_grant: got %b expected %b", port_ready, second_oh); else n_pass++;
        tick;
        port_en = 3'b000;
        arready = 1'b1;
        tick;
        arready = 1'b0;
        rvalid = 1'b1;
        tick;
        rvalid = 1'b0;
        @(negedge clk);
        n_checks++; if (port_valid !== second_oh) $display("FAIL wrap_second_valid: got %b expected %b", port_valid, second_oh); else n_pass++;
    endtask

    task automatic test_async_reset;
        tick;
        port_en = 3'b100;
        port_addr[95:64] = 32'h8000_0300;
        @(negedge clk);
        n_checks++; if (port_ready !== 3'b100) $display("FAIL arst_grant: got %b expected 100", port_ready); else n_pass++;
        tick;
        port_en = 3'b000;
        arready = 1'b1;
        tick;
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = 64'h5555_AAAA_5555_AAAA;
        #1;
        n_checks++; if (rready !== 1'b1) $display("FAIL arst_in_r: rready %b expected 1", rready); else n_pass++;
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if ({rready, arvalid, awvalid, wvalid, bready, port_valid} !== 8'b0) $display("FAIL arst_outputs: got %b expected 0", {rready, arvalid, awvalid, wvalid, bready, port_valid}); else n_pass++;
        n_checks++; if ({arid, araddr, port_rdata} !== '0) $display("FAIL arst_regs: arid %h araddr %h rdata %h expected 0", arid, araddr, port_rdata); else n_pass++;
        tick;
        rvalid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (port_valid !== 3'b000) $display("FAIL arst_no_valid: got %b expected 000", port_valid); else n_pass++;
    endtask

    // All three ports request continuously with a zero-wait-state slave
    task automatic test_round_robin;
        logic [2:0] exp_oh [6];
`ifdef YSYX_22041752_ARB_FIXED_PRIO_EN
        exp_oh = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
        exp_oh = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
        tick;
        port_en = 3'b111;
        arready = 1'b1;
        rvalid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rdata = 64'(k + 16);
            @(negedge clk);
            n_checks++; if (port_ready !== exp_oh[k]) $display("FAIL rr_grant_%0d: got %b expected %b", k, port_ready, exp_oh[k]); else n_pass++;
            tick;
            tick;
            tick;
            @(negedge clk);
            n_checks++; if ({port_valid, port_ready} !== {exp_oh[k], 3'b000}) $display("FAIL rr_valid_%0d: valid %b ready %b expected %b 000", k, port_valid, port_ready, exp_oh[k]); else n_pass++;
            n_checks++; if (port_rdata !== 64'(k + 16)) $display("FAIL rr_rdata_%0d: got %h expected %h", k, port_rdata, 64'(k + 16)); else n_pass++;
            tick;
        end
        port_en = 3'b000;
        arready = 1'b0;
        rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_split();
        test_wrap_ptr();
        test_async_reset();
        test_round_robin();
        repeat (3) tick;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
